// File: rtl/id_gen.sv
// Serializes "<letter><decimal digits><SEP>" as a valid/ready byte stream.
// The binary number is converted to BCD by shift-add-3, one bit per clock.
module id_gen #(
  parameter int unsigned NUM_W  = 10,
  parameter int unsigned DIGITS = 4,
  parameter logic [7:0]  SEP    = 8'h20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       letter,
  input  logic [NUM_W-1:0] num,
  input  logic             ready,
  output logic [7:0]       char,
  output logic             char_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(NUM_W + 1);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_EMIT_L, S_EMIT_D, S_EMIT_S
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         letter_q, letter_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         char_d;
  logic               char_valid_d, busy_d, done_d, err_d;

  logic [BCD_W-1:0]   bcd_adj, bcd_shift;
  logic [IDX_W-1:0]   lead;
  logic               xfer;

  function automatic logic letter_ok(input logic [7:0] l);
    return ((l >= 8'h41) && (l <= 8'h5A)) || ((l >= 8'h61) && (l <= 8'h7A));
  endfunction

  function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] b,
                                          input logic [IDX_W-1:0] i);
    return b[int'(i) * 4 +: 4];
  endfunction

  assign xfer = char_valid & ready;

  // One double-dabble step and the most significant nonzero digit of its result
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[BCD_W-2:0], num_q[NUM_W-1]};
    lead = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_shift[i*4 +: 4] != 4'd0) lead = IDX_W'(i);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    letter_d     = letter_q;
    num_d        = num_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    char_d       = char;
    char_valid_d = char_valid;
    done_d       = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (letter_ok(letter)) begin
            letter_d = letter;
            num_d    = num;
            bcd_d    = '0;
            cnt_d    = '0;
            state_d  = S_CONV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CONV: begin
        bcd_d = bcd_shift;
        num_d = {num_q[NUM_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_W - 1)) begin
          idx_d        = lead;
          char_d       = letter_q;
          char_valid_d = 1'b1;
          state_d      = S_EMIT_L;
        end
      end
      S_EMIT_L: begin
        if (xfer) begin
          char_d  = {4'h3, digit_at(bcd_q, idx_q)};
          state_d = S_EMIT_D;
        end
      end
      S_EMIT_D: begin
        if (xfer) begin
          if (idx_q == '0) begin
            char_d  = SEP;
            state_d = S_EMIT_S;
          end else begin
            idx_d  = idx_q - IDX_W'(1);
            char_d = {4'h3, digit_at(bcd_q, idx_q - IDX_W'(1))};
          end
        end
      end
      S_EMIT_S: begin
        if (xfer) begin
          char_d       = 8'h00;
          char_valid_d = 1'b0;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      letter_q   <= '0;
      num_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      char       <= '0;
      char_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      letter_q   <= letter_d;
      num_q      <= num_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      char       <= char_d;
      char_valid <= char_valid_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_id_gen.sv
// Bench for id_gen: directed cases plus random requests against a decimal-string model.
module tb_id_gen;

  localparam int unsigned NUM_W = 10;
  localparam logic [7:0]  SEP   = 8'h20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [7:0]       letter;
  logic [NUM_W-1:0] num;
  logic             ready;
  logic [7:0]       char;
  logic             char_valid, busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  id_gen #(.NUM_W(NUM_W), .DIGITS(4), .SEP(SEP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .letter(letter), .num(num),
    .ready(ready), .char(char), .char_valid(char_valid), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected stream: the letter, num in decimal without leading zeros, then SEP.
  task automatic build(input logic [7:0] l, input int unsigned n);
    logic [7:0] d[$];
    int unsigned v;
    v = n;
    exp_q.delete();
    if (v == 0) d.push_front(8'h30);
    while (v > 0) begin
      d.push_front(8'(8'h30 + v % 10));
      v = v / 10;
    end
    exp_q.push_back(l);
    foreach (d[i]) exp_q.push_back(d[i]);
    exp_q.push_back(SEP);
  endtask

  // mode 0: ready always high; 1: random stalls; 2: 3-cycle stall on '2' plus a start while busy
  task automatic run_req(input logic [7:0] l, input int unsigned n, input int mode);
    build(l, n);
    start  = 1'b1;
    letter = l;
    num    = NUM_W'(n);
    ready  = (mode == 0);
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    for (int j = 0; j < int'(NUM_W); j++) begin
      chk("conv_valid_low", char_valid, 0);
      step();
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      int stalls;
      stalls = 0;
      if (mode == 1) stalls = int'($urandom_range(0, 2));
      if (mode == 2 && exp_q[i] == 8'h32) stalls = 3;
      for (int s = 0; s <= stalls; s++) begin
        chk("char_valid", char_valid, 1);
        chk("char", char, exp_q[i]);
        chk("busy_stream", busy, 1);
        chk("no_err_busy", err, 0);
        ready = (s == stalls);
        if (mode == 2 && s == 1) begin
          start  = 1'b1;
          letter = 8'h42;
          num    = NUM_W'(5);
        end else begin
          start = 1'b0;
        end
        step();
      end
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("valid_end", char_valid, 0);
    chk("char_end", char, 0);
  endtask

  task automatic bad_start(input logic [7:0] l);
    start  = 1'b1;
    letter = l;
    num    = NUM_W'($urandom_range(0, 1023));
    step();
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_valid", char_valid, 0);
    step();
    chk("err_clear", err, 0);
    chk("err_valid2", char_valid, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    letter = 8'h00;
    num    = '0;
    ready  = 1'b0;
    #12;
    chk("rst_char", char, 0);
    chk("rst_valid", char_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step();

    run_req(8'h61, 123, 0);
    step();
    chk("done_one_cycle", done, 0);
    run_req(8'h5A, 0, 0);
    run_req(8'h41, 1023, 0);   // starts in the done cycle of the previous request
    run_req(8'h41, 7, 0);
    run_req(8'h41, 1234 % 1024, 2);
    step();
    chk("ignored_start_idle", busy, 0);
    chk("ignored_start_valid", char_valid, 0);

    bad_start(8'h35);
    bad_start(8'h40);
    bad_start(8'h5B);
    bad_start(8'h60);
    bad_start(8'h7B);
    run_req(8'h7A, 1000, 1);

    // Asynchronous reset in the middle of a stream
    start  = 1'b1;
    letter = 8'h61;
    num    = NUM_W'(123);
    ready  = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < int'(NUM_W) + 1; j++) step();
    chk("pre_rst_char", char, 8'h31);
    ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_char", char, 0);
    chk("arst_valid", char_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_valid", char_valid, 0);
    run_req(8'h61, 123, 0);

    for (int r = 0; r < 25; r++) begin
      logic [7:0] l;
      if ($urandom_range(0, 4) == 0) begin
        l = 8'h5B + 8'($urandom_range(0, 5));
        bad_start(l);
      end else begin
        l = ($urandom_range(0, 1) == 1) ? 8'(8'h41 + $urandom_range(0, 25))
                                        : 8'(8'h61 + $urandom_range(0, 25));
        run_req(l, $urandom_range(0, 1023), int'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
